mem_lsu: RTL and testbench
==========================

# mem_lsu

Memory-stage load/store unit sitting between the EX/MEM pipeline register and the word-wide data memory. The data memory takes one 32-bit word per access: a word index address, a single write enable, and a combinational read. This unit adds RV32I byte and halfword support on top of that:
- sub-word stores via a two-cycle read-modify-write, stalling the pipeline for one cycle;
- sign- or zero-extended sub-word loads;
- word accesses passed straight through.

## Interface
Parameters:
- DMEM_AW, 12, word-index width driven to data memory (4096 words)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  MEM stage holds a memory instruction
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address from ALU
- req_wdata  in  32  store data (rs2)
- load_data  out  32  extended load result, combinational
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; insert bubble into MEM/WB
- misalign  out  1  misaligned access flag (see Configuration)
- dmem_wen  out  1  data memory write enable
- dmem_addr  out  32  word index; req_addr[DMEM_AW+1:2] zero-extended
- dmem_wdata  out  32  data memory write data
- dmem_rdata  in  32  data memory combinational read data

## Operation
State machine: IDLE, WRITE. Internal registers:
- wr_idx (DMEM_AW bits)
- wr_word (32 bits)

IDLE:
- dmem_addr = word index of req_addr.
- Load (req_valid=1, req_we=0):
  - select the byte (addr[1:0]) or halfword (addr[1]) from dmem_rdata;
  - B/H sign-extend, BU/HU zero-extend, W passes through;
  - no stall.
- SW (funct3 010): dmem_wen=1, dmem_wdata=req_wdata, no stall, stay IDLE.
- SB/SH:
  - stall=1, dmem_wen=0;
  - wr_word <= dmem_rdata with the target byte/halfword lane replaced by req_wdata[7:0]/[15:0];
  - wr_idx <= word index;
  - go to WRITE.
- req_valid=0, or reserved funct3 (011, 110, 111; 100/101 for stores): no write, load_data=0, no stall.

WRITE:
- dmem_wen=1, dmem_addr=wr_idx, dmem_wdata=wr_word, stall=0.
- Request inputs are ignored: they are the same held instruction.
- Unconditionally return to IDLE.

When the unit is not writing, dmem_wdata = req_wdata. dmem_wen, stall and misalign are never asserted with req_valid=0 in IDLE.

## Timing
- Loads and SW: 0 extra cycles; write commits on the same rising edge the EX/MEM register advances.
- SB/SH: 2 cycles. Cycle 1 stall=1 (merge registered); cycle 2 write commits and the pipeline advances.
- A load or store immediately after a sub-word store reads the merged word, since the write committed at the end of WRITE.
- Reset: asynchronous to IDLE; wr_idx=0, wr_word=0.
- Reset asserted during WRITE: state is IDLE immediately, dmem_wen drops the same cycle, no write occurs, stall=0.
- During reset: stall=0, dmem_wen=0, misalign=0.

## Configuration
Macro: LSU_MISALIGN_TRAP_EN.

Defined:
- misalign=1 combinationally when req_valid=1 and the access is misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0.
- When misaligned:
  - a store is suppressed (no dmem_wen, no WRITE entry, stall=0);
  - load_data=0.

Undefined:
- misalign tied 0.
- Offending low address bits are ignored: H uses addr[1], W ignores addr[1:0].

## Test plan
- SW addr 0x10, wdata 0xDEADBEEF → same cycle dmem_wen=1, dmem_addr=4, dmem_wdata=0xDEADBEEF, stall=0.
- mem[4]=0x11223344, SB addr 0x13, wdata 0x000000AA:
  - cycle 1: stall=1, dmem_wen=0;
  - cycle 2: dmem_wen=1, addr 4, wdata 0xAA223344, stall=0.
- mem[4]=0x8022F344:
  - LB 0x11 → 0xFFFFFFF3; LBU 0x11 → 0x000000F3;
  - LH 0x12 → 0xFFFF8022; LHU 0x12 → 0x00008022; LW 0x10 → 0x8022F344.
- SH 0x16 wdata 0x5555 with mem[5]=0xFFFFFFFF, then LW 0x14 next instruction → 0x5555FFFF.
- SB in progress, rst pulsed during WRITE → no write; mem word unchanged; stall=0; next SW completes normally.
- SH addr 0x11:
  - with LSU_MISALIGN_TRAP_EN → misalign=1, no dmem_wen, stall=0;
  - without → misalign=0, low halfword of word 4 written after 2 cycles.

Source files
------------

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: sub-word loads, RMW sub-word stores.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module mem_lsu #(
  parameter int DMEM_AW = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misalign,
  output logic        dmem_wen,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [DMEM_AW-1:0] wr_idx_q, wr_idx_d;
  logic [31:0]        wr_word_q, wr_word_d;

  logic f_b, f_h, f_w, f_bu, f_hu;
  logic idle, mis_raw;
  logic ld_ok, st_ok, sw_go, sub_go;
  logic [DMEM_AW-1:0] req_idx;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] merged;
  logic        unused_addr;

  assign f_b  = (req_funct3 == 3'b000);
  assign f_h  = (req_funct3 == 3'b001);
  assign f_w  = (req_funct3 == 3'b010);
  assign f_bu = (req_funct3 == 3'b100);
  assign f_hu = (req_funct3 == 3'b101);

  assign idle        = (state_q == IDLE);
  assign req_idx     = req_addr[DMEM_AW+1:2];
  assign unused_addr = ^req_addr[31:DMEM_AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_raw = ((f_h | f_hu) & req_addr[0])
                 | (f_w & (|req_addr[1:0]));
`else
  assign mis_raw = 1'b0;
`endif

  assign ld_ok  = idle & req_valid & ~req_we & ~mis_raw;
  assign st_ok  = idle & req_valid & req_we & ~mis_raw & ~rst;
  assign sw_go  = st_ok & f_w;
  assign sub_go = st_ok & (f_b | f_h);

  always_comb begin
    byte_sel = 8'h00;
    case (req_addr[1:0])
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
  end

  assign half_sel = req_addr[1] ? dmem_rdata[31:16]
                                : dmem_rdata[15:0];

  always_comb begin
    load_data = 32'h0;
    if (ld_ok) begin
      case (req_funct3)
        3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
        3'b100:  load_data = {24'h0, byte_sel};
        3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
        3'b101:  load_data = {16'h0, half_sel};
        3'b010:  load_data = dmem_rdata;
        default: load_data = 32'h0;
      endcase
    end
  end

  // Lane replacement for the read-modify-write merge
  always_comb begin
    merged = dmem_rdata;
    if (f_b) begin
      case (req_addr[1:0])
        2'd0:    merged[7:0]   = req_wdata[7:0];
        2'd1:    merged[15:8]  = req_wdata[7:0];
        2'd2:    merged[23:16] = req_wdata[7:0];
        default: merged[31:24] = req_wdata[7:0];
      endcase
    end else if (req_addr[1]) begin
      merged[31:16] = req_wdata[15:0];
    end else begin
      merged[15:0] = req_wdata[15:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    wr_word_d = wr_word_q;
    case (state_q)
      IDLE: begin
        if (sub_go) begin
          state_d   = WRITE;
          wr_idx_d  = req_idx;
          wr_word_d = merged;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_idx_q  <= '0;
      wr_word_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      wr_word_q <= wr_word_d;
    end
  end

  assign stall      = sub_go;
  assign misalign   = idle & req_valid & mis_raw & ~rst;
  assign dmem_wen   = ~rst & (~idle | sw_go);
  assign dmem_addr  = {{(32-DMEM_AW){1'b0}},
                       idle ? req_idx : wr_idx_q};
  assign dmem_wdata = idle ? req_wdata : wr_word_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a word-wide memory model.
// Misalign expectations follow LSU_MISALIGN_TRAP_EN.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] load_data;
  logic        stall;
  logic        misalign;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  logic [31:0] mem [0:4095];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign dmem_rdata = mem[dmem_addr[11:0]];

  always @(posedge clk)
    if (dmem_wen) mem[dmem_addr[11:0]] <= dmem_wdata;

  mem_lsu #(.DMEM_AW(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .load_data(load_data),
    .stall(stall), .misalign(misalign),
    .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  task automatic drive(input logic v, input logic we,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] d);
    req_valid  = v;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 3'b010, 32'h10, 32'h1);
    #3;
    n_cmp++;
    if (dmem_wen !== 1'b0) begin
      n_err++;
      $display("FAIL rst_wen got %b want 0", dmem_wen);
    end
    n_cmp++;
    if (stall !== 1'b0 || misalign !== 1'b0) begin
      n_err++;
      $display("FAIL rst_stall got %b/%b want 0/0",
               stall, misalign);
    end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_sw();
    drive(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    #3;
    n_cmp++;
    if (dmem_wen !== 1'b1 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL sw_ctl got wen=%b stall=%b want 1/0",
               dmem_wen, stall);
    end
    n_cmp++;
    if (dmem_addr !== 32'd4 || dmem_wdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL sw_bus got %h/%h want 4/deadbeef",
               dmem_addr, dmem_wdata);
    end
    step();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    n_cmp++;
    if (mem[4] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL sw_mem got %h want deadbeef", mem[4]);
    end
  endtask

  task automatic test_sb();
    mem[4] = 32'h11223344;
    drive(1'b1, 1'b1, 3'b000, 32'h13, 32'h000000AA);
    #3;
    n_cmp++;
    if (stall !== 1'b1 || dmem_wen !== 1'b0) begin
      n_err++;
      $display("FAIL sb_c1 got stall=%b wen=%b want 1/0",
               stall, dmem_wen);
    end
    step();
    n_cmp++;
    if (dmem_wen !== 1'b1 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL sb_c2 got wen=%b stall=%b want 1/0",
               dmem_wen, stall);
    end
    n_cmp++;
    if (dmem_addr !== 32'd4 || dmem_wdata !== 32'hAA223344) begin
      n_err++;
      $display("FAIL sb_bus got %h/%h want 4/aa223344",
               dmem_addr, dmem_wdata);
    end
    step();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    n_cmp++;
    if (mem[4] !== 32'hAA223344) begin
      n_err++;
      $display("FAIL sb_mem got %h want aa223344", mem[4]);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [5];
    logic [31:0] ad [5];
    logic [31:0] ex [5];
    f3 = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    ad = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10};
    ex = '{32'hFFFFFFF3, 32'h000000F3, 32'hFFFF8022,
           32'h00008022, 32'h8022F344};
    mem[4] = 32'h8022F344;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, f3[i], ad[i], 32'h0);
      #3;
      n_cmp++;
      if (load_data !== ex[i] || stall !== 1'b0
          || dmem_wen !== 1'b0) begin
        n_err++;
        $display("FAIL load%0d got %h st=%b we=%b want %h",
                 i, load_data, stall, dmem_wen, ex[i]);
      end
      step();
    end
    drive(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
    #3;
    n_cmp++;
    if (load_data !== 32'h0) begin
      n_err++;
      $display("FAIL load_rsv got %h want 0", load_data);
    end
    drive(1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
    #1;
    n_cmp++;
    if (load_data !== 32'h0 || dmem_wen !== 1'b0
        || stall !== 1'b0 || misalign !== 1'b0) begin
      n_err++;
      $display("FAIL idle got ld=%h we=%b st=%b mis=%b want 0",
               load_data, dmem_wen, stall, misalign);
    end
    step();
  endtask

  task automatic test_back_to_back();
    mem[5] = 32'hFFFFFFFF;
    drive(1'b1, 1'b1, 3'b001, 32'h16, 32'h00005555);
    step();
    step();
    drive(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
    #3;
    n_cmp++;
    if (load_data !== 32'h5555FFFF) begin
      n_err++;
      $display("FAIL sh_lw got %h want 5555ffff", load_data);
    end
    step();
  endtask

  task automatic test_reset_during_write();
    mem[4] = 32'h11223344;
    drive(1'b1, 1'b1, 3'b000, 32'h10, 32'h00000077);
    step();
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dmem_wen !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL rstw_ctl got wen=%b stall=%b want 0/0",
               dmem_wen, stall);
    end
    step();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst = 1'b0;
    step();
    n_cmp++;
    if (mem[4] !== 32'h11223344) begin
      n_err++;
      $display("FAIL rstw_mem got %h want 11223344", mem[4]);
    end
    drive(1'b1, 1'b1, 3'b010, 32'h10, 32'h12345678);
    #3;
    n_cmp++;
    if (dmem_wen !== 1'b1 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL rstw_sw got wen=%b stall=%b want 1/0",
               dmem_wen, stall);
    end
    step();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    n_cmp++;
    if (mem[4] !== 32'h12345678) begin
      n_err++;
      $display("FAIL rstw_mem2 got %h want 12345678", mem[4]);
    end
  endtask

  task automatic test_misalign();
    mem[4] = 32'h11223344;
    drive(1'b1, 1'b1, 3'b001, 32'h11, 32'h0000BEEF);
    #3;
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++;
    if (misalign !== 1'b1 || dmem_wen !== 1'b0
        || stall !== 1'b0) begin
      n_err++;
      $display("FAIL mis_sh got m=%b we=%b st=%b want 1/0/0",
               misalign, dmem_wen, stall);
    end
    step();
    step();
    n_cmp++;
    if (mem[4] !== 32'h11223344) begin
      n_err++;
      $display("FAIL mis_mem got %h want 11223344", mem[4]);
    end
    drive(1'b1, 1'b0, 3'b010, 32'h12, 32'h0);
    #3;
    n_cmp++;
    if (misalign !== 1'b1 || load_data !== 32'h0) begin
      n_err++;
      $display("FAIL mis_lw got m=%b ld=%h want 1/0",
               misalign, load_data);
    end
    step();
`else
    n_cmp++;
    if (misalign !== 1'b0 || stall !== 1'b1) begin
      n_err++;
      $display("FAIL mis_sh got m=%b st=%b want 0/1",
               misalign, stall);
    end
    step();
    step();
    n_cmp++;
    if (mem[4] !== 32'h1122BEEF) begin
      n_err++;
      $display("FAIL mis_mem got %h want 1122beef", mem[4]);
    end
    drive(1'b1, 1'b0, 3'b010, 32'h12, 32'h0);
    #3;
    n_cmp++;
    if (misalign !== 1'b0 || load_data !== 32'h1122BEEF) begin
      n_err++;
      $display("FAIL mis_lw got m=%b ld=%h want 0/1122beef",
               misalign, load_data);
    end
    step();
`endif
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    #2;
    test_reset();
    test_sw();
    test_sb();
    test_loads();
    test_back_to_back();
    test_reset_during_write();
    test_misalign();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
